// File: rtl/joint_stepper_gen.sv
// rtl/joint_stepper_gen.sv - step/direction pulse generator for one joint
// Define JOINT_STEPPER_POSITION_EN to keep a signed step-position counter on jointFeedback.
module joint_stepper_gen #(
  parameter int WIDTH     = 32,
  parameter int PULSE_LEN = 100,
  parameter int DIR_SETUP = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jointEnable,
  input  logic [WIDTH-1:0] jointFreqCmd,
  output logic             DIR,
  output logic             STP,
  output logic             busy,
  output logic [WIDTH-1:0] jointFeedback
);

  localparam int PHASE_MAX = (PULSE_LEN > DIR_SETUP) ? PULSE_LEN : DIR_SETUP;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam logic [PW-1:0]    PULSE_LAST = PW'(PULSE_LEN - 1);
  localparam logic [PW-1:0]    SETUP_LAST = PW'(DIR_SETUP - 1);
  localparam logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(2 * PULSE_LEN);

  typedef enum logic [1:0] {S_IDLE, S_DIR_SETUP, S_STEP_HIGH, S_STEP_LOW} state_t;

  state_t           state;
  logic [PW-1:0]    phase_cnt;
  logic [WIDTH-1:0] period_cnt;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] eff_period;
  logic             go;
  logic             want_dir;
  logic             period_due;
  logic             decide;
  logic             dir_req;
  logic             step_req;
  logic             enter_high;

  // The last STEP_LOW cycle makes the IDLE decision so back-to-back steps
  // land exactly 2*PULSE_LEN apart at the clamped minimum period.
  always_comb begin
    mag        = jointFreqCmd[WIDTH-1] ? -jointFreqCmd : jointFreqCmd;
    eff_period = (mag > MIN_PERIOD) ? mag : MIN_PERIOD;
    period_due = period_cnt >= (eff_period - WIDTH'(1));
    go         = jointEnable && (jointFreqCmd != '0);
    want_dir   = !jointFreqCmd[WIDTH-1] && (jointFreqCmd != '0);
    decide     = (state == S_IDLE) || ((state == S_STEP_LOW) && (phase_cnt == '0));
    dir_req    = go && (want_dir != DIR);
    step_req   = go && !dir_req && period_due;
    enter_high = (decide && step_req) ||
                 ((state == S_DIR_SETUP) && go && (phase_cnt == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      DIR       <= 1'b0;
      STP       <= 1'b0;
      busy      <= 1'b0;
    end else if (decide) begin
      if (dir_req) begin
        DIR       <= want_dir;
        state     <= S_DIR_SETUP;
        phase_cnt <= SETUP_LAST;
        busy      <= 1'b1;
      end else if (step_req) begin
        state     <= S_STEP_HIGH;
        STP       <= 1'b1;
        phase_cnt <= PULSE_LAST;
        busy      <= 1'b1;
      end else begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end
    end else begin
      case (state)
        S_DIR_SETUP: begin
          if (!go) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (phase_cnt == '0) begin
            state     <= S_STEP_HIGH;
            STP       <= 1'b1;
            phase_cnt <= PULSE_LAST;
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end
        S_STEP_HIGH: begin
          if (phase_cnt == '0) begin
            state     <= S_STEP_LOW;
            STP       <= 1'b0;
            phase_cnt <= PULSE_LAST;
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end
        default: begin
          phase_cnt <= phase_cnt - PW'(1);
        end
      endcase
    end
  end

  // Starts saturated so the very first step is not held off by the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '1;
    end else if (enter_high) begin
      period_cnt <= '0;
    end else if (period_cnt != '1) begin
      period_cnt <= period_cnt + WIDTH'(1);
    end
  end

`ifdef JOINT_STEPPER_POSITION_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      jointFeedback <= '0;
    end else if (enter_high) begin
      jointFeedback <= DIR ? (jointFeedback + WIDTH'(1)) : (jointFeedback - WIDTH'(1));
    end
  end
`else
  assign jointFeedback = '0;
`endif

endmodule
